// File: rtl/uart_tx_fifo_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_cfg
// Purpose  : UART transmitter with a small transmit FIFO and a runtime
//            frame format (5-8 data bits, none/odd/even parity, 1 or 2
//            stop bits) and a runtime baud divisor.
// Ports    : Clk, Rst_n        - clock, asynchronous active-low reset
//            tx_data/tx_valid  - byte to queue, accepted when tx_ready=1
//            tx_ready          - FIFO not full
//            baud_div          - clocks per bit minus 1 (0 behaves as 1)
//            data_bits         - 0..3 selects 5..8 data bits
//            parity_mode       - 0/3 none, 1 odd, 2 even
//            stop2             - two stop bits when set
//            Rs232_Tx          - registered serial line (idle high)
//            Tx_Done           - one-cycle pulse after each frame
//            uart_state        - high while a frame is on the line
//            fifo_level        - FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_cfg #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic [1:0]       parity_mode,
  input  logic             stop2,
  output logic             Rs232_Tx,
  output logic             Tx_Done,
  output logic             uart_state,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int               c_ADDR_W = (LVL_W > 1) ? LVL_W - 1 : 1;
  localparam logic [LVL_W-1:0] c_FULL   = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Transmit FIFO
  // --------------------------------------------------------------------------
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0]    r_count;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_nempty;
  logic [7:0]          w_head;

  assign tx_ready      = (r_count != c_FULL);
  assign fifo_level    = r_count;
  assign w_push        = tx_valid && tx_ready;
  assign w_fifo_nempty = (r_count != '0);
  assign w_head        = r_mem[r_rd_ptr];

  // Storage needs no reset: occupancy is tracked by r_count alone.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame configuration derived from the head entry and live config inputs;
  // only sampled at the edge that starts a frame.
  // --------------------------------------------------------------------------
  logic [7:0]       w_mask;
  logic             w_par_even;
  logic             w_par_en;
  logic             w_par_bit;
  logic [DIV_W-1:0] w_div_eff;

  assign w_mask     = 8'hFF >> (2'd3 - data_bits);
  assign w_par_even = ^(w_head & w_mask);
  assign w_par_en   = (parity_mode == 2'd1) || (parity_mode == 2'd2);
  assign w_par_bit  = (parity_mode == 2'd1) ? ~w_par_even : w_par_even;
  assign w_div_eff  = (baud_div == '0) ? DIV_W'(1) : baud_div;

  // --------------------------------------------------------------------------
  // Serialiser FSM
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [DIV_W-1:0] r_baud_cnt;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [2:0]       r_last_idx;
  logic             r_par_en;
  logic             r_par_bit;
  logic             r_stop2;
  logic             r_stop_idx;
  logic             w_bit_done;
  logic             w_frame_end;
  logic             w_start_frame;

  assign w_bit_done    = (r_baud_cnt == r_div);
  assign w_frame_end   = (r_state == S_STOP) && w_bit_done && (r_stop_idx == r_stop2);
  // A frame starts from IDLE or directly out of the last stop bit, so
  // queued bytes go out back-to-back with no idle gap.
  assign w_start_frame = w_fifo_nempty && ((r_state == S_IDLE) || w_frame_end);
  assign w_pop         = w_start_frame;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_div      <= DIV_W'(1);
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_last_idx <= 3'd7;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      Rs232_Tx   <= 1'b1;
      Tx_Done    <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      Tx_Done <= 1'b0;
      if (w_start_frame) begin
        // Pop the head and freeze the frame format for the whole frame.
        r_state    <= S_START;
        uart_state <= 1'b1;
        Rs232_Tx   <= 1'b0;
        r_baud_cnt <= '0;
        r_div      <= w_div_eff;
        r_shift    <= w_head;
        r_bit_idx  <= '0;
        r_last_idx <= {1'b1, data_bits};
        r_par_en   <= w_par_en;
        r_par_bit  <= w_par_bit;
        r_stop2    <= stop2;
        r_stop_idx <= 1'b0;
        if (w_frame_end) Tx_Done <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            Rs232_Tx   <= 1'b1;
            uart_state <= 1'b0;
          end
          S_START: begin
            if (w_bit_done) begin
              r_baud_cnt <= '0;
              r_state    <= S_DATA;
              Rs232_Tx   <= r_shift[0];
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (w_bit_done) begin
              r_baud_cnt <= '0;
              if (r_bit_idx == r_last_idx) begin
                if (r_par_en) begin
                  r_state  <= S_PARITY;
                  Rs232_Tx <= r_par_bit;
                end else begin
                  r_state    <= S_STOP;
                  Rs232_Tx   <= 1'b1;
                  r_stop_idx <= 1'b0;
                end
              end else begin
                r_shift   <= r_shift >> 1;
                Rs232_Tx  <= r_shift[1];
                r_bit_idx <= r_bit_idx + 1'b1;
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
          end
          S_PARITY: begin
            if (w_bit_done) begin
              r_baud_cnt <= '0;
              r_state    <= S_STOP;
              Rs232_Tx   <= 1'b1;
              r_stop_idx <= 1'b0;
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (w_bit_done) begin
              r_baud_cnt <= '0;
              if (w_frame_end) begin
                r_state    <= S_IDLE;
                uart_state <= 1'b0;
                Tx_Done    <= 1'b1;
                Rs232_Tx   <= 1'b1;
              end else begin
                r_stop_idx <= 1'b1;
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
          end
          default: begin
            r_state    <= S_IDLE;
            Rs232_Tx   <= 1'b1;
            uart_state <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo_cfg
// Purpose  : Self-checking bench for uart_tx_fifo_cfg. Stimulus queues the
//            hand-computed line waveform of each frame; a monitor decodes
//            frames off Rs232_Tx and compares them on every Tx_Done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_cfg;

  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = 3;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic [7:0]       tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [DIV_W-1:0] baud_div = 16'd3;
  logic [1:0]       data_bits = 2'd3;
  logic [1:0]       parity_mode = 2'd0;
  logic             stop2 = 1'b0;
  logic             Rs232_Tx;
  logic             Tx_Done;
  logic             uart_state;
  logic [LVL_W-1:0] fifo_level;

  uart_tx_fifo_cfg #(
    .DIV_W     (DIV_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .LVL_W     (LVL_W)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity_mode(parity_mode),
    .stop2      (stop2),
    .Rs232_Tx   (Rs232_Tx),
    .Tx_Done    (Tx_Done),
    .uart_state (uart_state),
    .fifo_level (fifo_level)
  );

  always #5 Clk = ~Clk;

  // Expected frame: line level per bit period as a '0'/'1' string
  // (start bit first), bit period in clocks, and whether the frame must
  // start at the very edge the previous frame completed.
  typedef struct {
    string seq;
    int    period;
    bit    b2b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input string s, input int p, input bit b);
    exp_t e;
    e.seq    = s;
    e.period = p;
    e.b2b    = b;
    exp_q.push_back(e);
  endtask

  // Presents a byte and returns #1 after the edge that accepted it.
  task automatic push_byte(input logic [7:0] b);
    int t;
    t        = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    do begin
      @(posedge Clk);
      t++;
    end while (!tx_ready && t < 500);
    #1;
    tx_valid = 1'b0;
    if (t >= 500) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: byte %0h not accepted, required acceptance", b);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || uart_state !== 1'b0) && t < 3000) begin
      @(posedge Clk);
      t++;
    end
    if (t >= 3000) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: %0d frames outstanding, required 0", exp_q.size());
    end
    @(negedge Clk);
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  bit in_frame    = 1'b0;
  bit started_b2b = 1'b0;
  bit samples[$];

  task automatic check_frame();
    exp_t  e;
    string act_s;
    int    len;
    bit    bad;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_frame: got %0d-clock frame, required none", samples.size());
      return;
    end
    e   = exp_q.pop_front();
    len = e.seq.len() * e.period;
    chk("frame_len", samples.size(), len);
    chk("frame_b2b", {31'd0, started_b2b}, {31'd0, e.b2b});
    bad   = 1'b0;
    act_s = "";
    for (int i = 0; i < samples.size(); i++) begin
      if (i < len && samples[i] != (e.seq[i / e.period] == 8'h31)) bad = 1'b1;
    end
    for (int k = 0; k * e.period + e.period / 2 < samples.size(); k++) begin
      act_s = $sformatf("%s%0d", act_s, samples[k * e.period + e.period / 2]);
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL frame_bits: got %s required %s (period %0d)", act_s, e.seq, e.period);
    end
  endtask

  always @(negedge Clk) begin
    if (!Rst_n) begin
      in_frame = 1'b0;
      samples.delete();
    end else if (Tx_Done) begin
      if (!in_frame) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_done_spurious: got pulse, required none");
      end else begin
        check_frame();
      end
      samples.delete();
      if (Rs232_Tx == 1'b0) begin
        in_frame    = 1'b1;
        started_b2b = 1'b1;
        samples.push_back(1'b0);
      end else begin
        in_frame = 1'b0;
        chk("uart_state_fall", {31'd0, uart_state}, 32'd0);
      end
    end else if (in_frame) begin
      samples.push_back(Rs232_Tx);
    end else if (Rs232_Tx == 1'b0) begin
      in_frame    = 1'b1;
      started_b2b = 1'b0;
      samples.push_back(1'b0);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_line",  {31'd0, Rs232_Tx},   32'd1);
    chk("rst_done",  {31'd0, Tx_Done},    32'd0);
    chk("rst_state", {31'd0, uart_state}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready},   32'd1);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // 1: 8N1, 0xA5, period 4, start bit one clock after acceptance
    baud_div = 16'd3; data_bits = 2'd3; parity_mode = 2'd0; stop2 = 1'b0;
    push_exp("0101001011", 4, 1'b0);
    push_byte(8'hA5);
    @(negedge Clk);
    chk("lat_line_hi", {31'd0, Rs232_Tx}, 32'd1);
    @(negedge Clk);
    chk("lat_line_lo", {31'd0, Rs232_Tx}, 32'd0);
    chk("lat_state",   {31'd0, uart_state}, 32'd1);
    wait_idle();

    // 2: 8E1 then 7O2 (bit 7 of 0xC1 must be ignored, parity over 7 bits)
    parity_mode = 2'd2;
    push_exp("01010010101", 4, 1'b0);
    push_byte(8'hA5);
    wait_idle();
    data_bits = 2'd2; parity_mode = 2'd1; stop2 = 1'b1;
    push_exp("01000001111", 4, 1'b0);
    push_byte(8'hC1);
    wait_idle();

    // 3: burst of six bytes, period 2, FIFO fills then stalls
    baud_div = 16'd1; data_bits = 2'd3; parity_mode = 2'd0; stop2 = 1'b0;
    push_exp("0100000001", 2, 1'b0);
    push_exp("0010000001", 2, 1'b1);
    push_exp("0110000001", 2, 1'b1);
    push_exp("0001000001", 2, 1'b1);
    push_exp("0101000001", 2, 1'b1);
    push_exp("0011000001", 2, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      push_byte(8'(i));
      if (i == 5) begin
        chk("burst_level", {29'd0, fifo_level}, 32'd4);
        chk("burst_ready", {31'd0, tx_ready},   32'd0);
      end
    end
    wait_idle();

    // 4: config change mid-frame only affects the next frame
    baud_div = 16'd3; stop2 = 1'b0;
    push_exp("0001111001", 4, 1'b0);
    push_byte(8'h3C);
    repeat (10) @(posedge Clk);
    #1;
    baud_div = 16'd7; stop2 = 1'b1;
    push_exp("00011110011", 8, 1'b1);
    push_byte(8'h3C);
    wait_idle();

    // 5: reset during DATA of the second of three queued frames
    baud_div = 16'd3; stop2 = 1'b0;
    push_exp("0100010001", 4, 1'b0);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    begin
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 1000) begin
        @(posedge Clk);
        t++;
      end
      chk("abort_wait", {31'd0, (t >= 1000)}, 32'd0);
    end
    repeat (8) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    chk("abort_line",  {31'd0, Rs232_Tx},   32'd1);
    chk("abort_level", {29'd0, fifo_level}, 32'd0);
    chk("abort_state", {31'd0, uart_state}, 32'd0);
    chk("abort_done",  {31'd0, Tx_Done},    32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (30) @(negedge Clk);
    chk("post_rst_line",  {31'd0, Rs232_Tx},   32'd1);
    chk("post_rst_state", {31'd0, uart_state}, 32'd0);

    // 6: baud_div=0 behaves as 1; push and pop on the same edge at level 2
    baud_div = 16'd0;
    push_exp("0010110101", 2, 1'b0);
    push_exp("0000000001", 2, 1'b1);
    push_exp("0111111111", 2, 1'b1);
    push_exp("0100000011", 2, 1'b1);
    push_byte(8'h5A);
    push_byte(8'h00);
    push_byte(8'hFF);
    repeat (18) @(posedge Clk);
    @(negedge Clk);
    chk("pp_level_before", {29'd0, fifo_level}, 32'd2);
    push_byte(8'h81);
    chk("pp_level_after", {29'd0, fifo_level}, 32'd2);
    wait_idle();
    chk("final_level", {29'd0, fifo_level}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
